// File: rtl/regfile_pkg.sv
// regfile_pkg: shared CPU defines for the register file (widths, zero word, enable/reset encodings); REGFILE_BYPASS_EN is consumed by regfile_rport
package regfile_pkg;
    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 5;
    localparam logic [31:0] ZERO_WORD = 32'h0000_0000;
    localparam logic [4:0] NOP_REG_ADDR = 5'd0;
    localparam logic WRITE_ENABLE = 1'b1;
    localparam logic WRITE_DISABLE = 1'b0;
    localparam logic READ_ENABLE = 1'b1;
    localparam logic READ_DISABLE = 1'b0;
    localparam logic RST_ENABLE = 1'b0;
    localparam logic RST_DISABLE = 1'b1;
endpackage

// File: rtl/regfile_if.sv
// regfile_if: writeback write port plus two read ports; master drives requests, slave (the register file) returns read data
interface regfile_if
    import regfile_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) ();
    logic              we;
    logic [ADDR_W-1:0] waddr;
    logic [DATA_W-1:0] wdata;
    logic              re1;
    logic [ADDR_W-1:0] raddr1;
    logic [DATA_W-1:0] rdata1;
    logic              re2;
    logic [ADDR_W-1:0] raddr2;
    logic [DATA_W-1:0] rdata2;

    modport master (
        output we, waddr, wdata, re1, raddr1, re2, raddr2,
        input  rdata1, rdata2
    );

    modport slave (
        input  we, waddr, wdata, re1, raddr1, re2, raddr2,
        output rdata1, rdata2
    );
endinterface

// File: rtl/regfile_rport.sv
// regfile_rport: combinational read port selecting zero, bypassed write data or stored data; write bypass only when REGFILE_BYPASS_EN is defined
module regfile_rport
    import regfile_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              resetn,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    input  logic [DATA_W-1:0] stored,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);
`ifdef REGFILE_BYPASS_EN
    localparam logic BYPASS = 1'b1;
`else
    localparam logic BYPASS = 1'b0;
`endif

    logic blank;
    logic hit;

    // Reset, disabled port and index 0 force zero; otherwise a matching same-cycle write overrides storage when bypass is built in
    always_comb begin
        blank = resetn == RST_ENABLE || re == READ_DISABLE || raddr == ADDR_W'(NOP_REG_ADDR);
        hit   = BYPASS && we == WRITE_ENABLE && raddr == waddr;
        rdata = blank ? DATA_W'(ZERO_WORD) : hit ? wdata : stored;
    end
endmodule

// File: rtl/regfile.sv
// regfile: 2**ADDR_W x DATA_W register file, register 0 hardwired zero, one write and two combinational reads per cycle; REGFILE_BYPASS_EN enables write-to-read bypass
module regfile
    import regfile_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input logic       clk,
    input logic       resetn,
    regfile_if.slave  bus
);
    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] regs_q [DEPTH];
    logic [DATA_W-1:0] regs_d [DEPTH];
    logic              wr_en;

    // Next storage state: take the write for any nonzero index and pin register 0 at zero
    always_comb begin
        wr_en  = bus.we != WRITE_DISABLE && bus.waddr != ADDR_W'(NOP_REG_ADDR);
        regs_d = regs_q;
        if (wr_en) regs_d[bus.waddr] = bus.wdata;
        regs_d[0] = DATA_W'(ZERO_WORD);
    end

    // Synchronous active-low clear; a write presented while in reset is dropped
    always_ff @(posedge clk) begin
        if (resetn == RST_ENABLE) regs_q <= '{default: DATA_W'(ZERO_WORD)};
        else regs_q <= regs_d;
    end

    regfile_rport #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_rport1 (
        .resetn (resetn),
        .re     (bus.re1),
        .raddr  (bus.raddr1),
        .stored (regs_q[bus.raddr1]),
        .we     (bus.we),
        .waddr  (bus.waddr),
        .wdata  (bus.wdata),
        .rdata  (bus.rdata1)
    );

    regfile_rport #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_rport2 (
        .resetn (resetn),
        .re     (bus.re2),
        .raddr  (bus.raddr2),
        .stored (regs_q[bus.raddr2]),
        .we     (bus.we),
        .waddr  (bus.waddr),
        .wdata  (bus.wdata),
        .rdata  (bus.rdata2)
    );
endmodule
